// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: requester tags and memory port widths shared by the arbiter slice
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef logic tag_t;
  localparam tag_t TAG_FETCH = 1'b0;
  localparam tag_t TAG_DATA = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals of the unified memory arbiter
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;
  logic halt, f_req, f_gnt, f_flush, f_rvalid, d_req, d_gnt, d_rvalid, mem_re;
  logic [ADDR_W-1:0] f_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] f_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [BE_W-1:0] d_we, mem_we;
  modport master(
    output halt, f_req, f_addr, f_flush, d_req, d_addr, d_wdata, d_we, mem_rdata,
    input f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_we, mem_re
  );
  modport slave(
    input halt, f_req, f_addr, f_flush, d_req, d_addr, d_wdata, d_we, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// resp_tag_pipe: DEPTH-deep {valid, tag} shift register tracking reads in flight
module resp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  tag_t in_tag,
  input  logic squash,
  input  tag_t squash_tag,
  output logic out_valid,
  output tag_t out_tag
);
  logic [DEPTH-1:0] valid;
  tag_t [DEPTH-1:0] tag;
  always_ff @(posedge clk) begin
    valid[0] <= !rst && in_valid;
    tag[0] <= in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      valid[i] <= !rst && valid[i-1] && !(squash && tag[i-1] == squash_tag);
      tag[i] <= tag[i-1];
    end
  end
  // the entry leaving this cycle is squashed at the output rather than in the register
  assign out_valid = valid[DEPTH-1] && !(squash && tag[DEPTH-1] == squash_tag);
  assign out_tag = tag[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access with starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic f_pri, f_gnt, d_gnt, rd, last_valid;
  tag_t last_tag;
  assign f_pri = bus.f_req && starve_cnt == SW'(STARVE_LIMIT);
  assign f_gnt = !bus.halt && !rst && bus.f_req && (f_pri || !bus.d_req);
  assign d_gnt = !bus.halt && !rst && bus.d_req && !f_pri;
  assign rd = f_gnt || (d_gnt && bus.d_we == '0);
  assign bus.f_gnt = f_gnt;
  assign bus.d_gnt = d_gnt;
  assign bus.mem_re = rd;
  assign bus.mem_we = d_gnt ? bus.d_we : '0;
  assign bus.mem_addr = f_gnt ? bus.f_addr : d_gnt ? bus.d_addr : '0;
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
  always_ff @(posedge clk)
    if (rst || f_gnt || !bus.f_req) starve_cnt <= '0;
    else if (!bus.halt && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  resp_tag_pipe #(.DEPTH(LATENCY)) pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(rd),
    .in_tag(d_gnt ? TAG_DATA : TAG_FETCH),
    .squash(bus.f_flush),
    .squash_tag(TAG_FETCH),
    .out_valid(last_valid),
    .out_tag(last_tag)
  );
  assign bus.f_rvalid = !rst && last_valid && last_tag == TAG_FETCH;
  assign bus.d_rvalid = !rst && last_valid && last_tag == TAG_DATA;
  assign bus.f_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench over arbiters with LATENCY 1, 2 and 3
module tb_mem_port_arbiter;
  typedef struct packed {
    logic f_gnt, d_gnt, f_rvalid, d_rvalid, mem_re;
    logic [3:0] mem_we;
    logic [31:0] mem_addr, mem_wdata, f_rdata, d_rdata;
  } out_t;
  typedef struct {
    logic tag;
    int due;
  } exp_t;
  logic clk = 0, rst = 1;
  logic halt = 0, f_req = 0, f_flush = 0, d_req = 0;
  logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_we = 0;
  int sel = 1, cyc = 0, checks = 0, errors = 0;
  out_t outs [1:3];
  out_t o;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 1; g <= 3; g++) begin : gen
    mem_port_arbiter_if bus ();
    assign bus.halt = sel == g && halt;
    assign bus.f_req = sel == g && f_req;
    assign bus.f_flush = sel == g && f_flush;
    assign bus.d_req = sel == g && d_req;
    assign bus.f_addr = sel == g ? f_addr : '0;
    assign bus.d_addr = sel == g ? d_addr : '0;
    assign bus.d_wdata = sel == g ? d_wdata : '0;
    assign bus.d_we = sel == g ? d_we : '0;
    assign bus.mem_rdata = 32'hC0DE_0000 + 32'(cyc);
    assign outs[g] = {bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid, bus.mem_re, bus.mem_we,
                      bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata};
    mem_port_arbiter #(.LATENCY(g), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  end
  assign o = outs[sel];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic gnt(string n, logic ef, logic ed);
    chk({n, "_f_gnt"}, 32'(o.f_gnt), 32'(ef));
    chk({n, "_d_gnt"}, 32'(o.d_gnt), 32'(ed));
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic tag, int lat);
    sb.push_back('{tag, cyc + lat});
  endtask
  always @(negedge clk) begin
    chk("rvalid_excl", 32'(o.f_rvalid & o.d_rvalid), 0);
    if (o.f_rvalid || o.d_rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", {30'd0, o.f_rvalid, o.d_rvalid}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_tag", 32'(o.d_rvalid), 32'(e.tag));
        chk("resp_cycle", cyc, e.due);
        chk("resp_data", o.d_rvalid ? o.d_rdata : o.f_rdata, 32'hC0DE_0000 + 32'(e.due));
      end
    end
  end
  initial begin
    f_req = 1;
    d_req = 1;
    repeat (2) next();
    @(negedge clk);
    gnt("reset", 0, 0);
    chk("reset_mem_re", 32'(o.mem_re), 0);
    next();
    rst = 0; f_req = 0; d_req = 0;
    next();
    f_req = 1; f_addr = 32'h100;
    @(negedge clk);
    gnt("fetch", 1, 0);
    chk("fetch_mem_re", 32'(o.mem_re), 1);
    chk("fetch_mem_addr", o.mem_addr, 32'h100);
    chk("fetch_mem_we", 32'(o.mem_we), 0);
    chk("fetch_mem_wdata", o.mem_wdata, 0);
    push(0, 1);
    next();
    f_req = 0;
    @(negedge clk);
    chk("idle_mem_re", 32'(o.mem_re), 0);
    chk("idle_mem_addr", o.mem_addr, 0);
    repeat (2) next();
    for (int i = 0; i < 10; i++) begin
      next();
      f_req = 1; d_req = 1; f_addr = 32'h104; d_addr = 32'h200;
      @(negedge clk);
      gnt($sformatf("starve%0d", i), i == 4 || i == 9, !(i == 4 || i == 9));
      chk("starve_mem_addr", o.mem_addr, (i == 4 || i == 9) ? 32'h104 : 32'h200);
      push(!(i == 4 || i == 9), 1);
    end
    next();
    f_req = 0; d_req = 0;
    repeat (2) next();
    next();
    d_req = 1; d_addr = 32'h203; d_we = 4'b1000; d_wdata = 32'hAB00_0000;
    @(negedge clk);
    gnt("write", 0, 1);
    chk("write_mem_we", 32'(o.mem_we), 32'b1000);
    chk("write_mem_re", 32'(o.mem_re), 0);
    chk("write_mem_wdata", o.mem_wdata, 32'hAB00_0000);
    chk("write_mem_addr", o.mem_addr, 32'h203);
    next();
    d_req = 0; d_we = 0; d_wdata = 0;
    repeat (3) next();
    next();
    sel = 3; f_req = 1; f_addr = 32'h40;
    @(negedge clk);
    gnt("flush_f0", 1, 0);
    next();
    f_req = 0; d_req = 1; d_addr = 32'h80;
    @(negedge clk);
    gnt("flush_d1", 0, 1);
    push(1, 3);
    next();
    d_req = 0; f_flush = 1; f_req = 1; f_addr = 32'h44;
    @(negedge clk);
    gnt("flush_redirect", 1, 0);
    chk("flush_f_rvalid", 32'(o.f_rvalid), 0);
    push(0, 3);
    next();
    f_flush = 0; f_req = 0;
    repeat (4) next();
    next();
    sel = 2; f_req = 1; d_req = 1; f_addr = 32'h300; d_addr = 32'h400;
    @(negedge clk);
    gnt("halt_c0", 0, 1);
    push(1, 2);
    for (int i = 1; i <= 3; i++) begin
      next();
      halt = 1;
      @(negedge clk);
      gnt($sformatf("halt_c%0d", i), 0, 0);
      chk("halt_mem_re", 32'(o.mem_re), 0);
      chk("halt_mem_we", 32'(o.mem_we), 0);
    end
    for (int i = 4; i <= 7; i++) begin
      next();
      halt = 0;
      @(negedge clk);
      gnt($sformatf("post_halt_c%0d", i), i == 7, i != 7);
      push(i != 7, 2);
    end
    next();
    f_req = 0; d_req = 0;
    repeat (3) next();
    next();
    f_req = 1; f_addr = 32'h500;
    @(negedge clk);
    gnt("rst_read", 1, 0);
    next();
    f_req = 0; rst = 1;
    @(negedge clk);
    gnt("rst_cycle", 0, 0);
    next();
    rst = 0;
    repeat (3) next();
    for (int i = 0; i < 3; i++) begin
      next();
      f_req = 1; d_req = 1; d_we = 4'hF; d_addr = 32'h600;
      @(negedge clk);
      gnt($sformatf("prebuild%0d", i), 0, 1);
    end
    next();
    rst = 1;
    @(negedge clk);
    gnt("rst_held", 0, 0);
    for (int i = 0; i < 5; i++) begin
      next();
      rst = 0;
      @(negedge clk);
      gnt($sformatf("after_rst%0d", i), i == 4, i != 4);
      if (i == 4) push(0, 2);
    end
    next();
    f_req = 0; d_req = 0; d_we = 0;
    repeat (4) next();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (word reads) and the execute-stage data access (reads, and writes with byte enables).
- Each cycle it grants at most one requester and drives the memory port. It tags every read in flight so the returning data goes back to the right requester.
- Data accesses win by default. A starvation counter guarantees fetch progress. A fetch flush (taken branch or exception) squashes stale fetch responses.

Parameters:
LATENCY, 1, memory read latency in cycles (>=1); a read granted in cycle N returns data in cycle N+LATENCY
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch takes priority (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
halt  in  1  blocks all new grants; reads already in flight still complete
f_req  in  1  fetch read request
f_addr  in  32  fetch address
f_gnt  out  1  fetch granted this cycle (combinational)
f_flush  in  1  squash all fetch reads already in flight
f_rvalid  out  1  fetch read data valid
f_rdata  out  32  fetch read data
d_req  in  1  data request
d_addr  in  32  data address
d_wdata  in  32  store data, already lane-aligned
d_we  in  4  byte enables; 0 means read
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  data read data valid
d_rdata  out  32  data read data
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_we  out  4  memory byte write enables
mem_re  out  1  memory read enable
mem_rdata  in  32  memory read data

Behaviour:
- Grant logic (combinational):
  - When halt or rst is high: f_gnt = d_gnt = 0.
  - Otherwise, fetch has priority when f_req and starve_cnt == STARVE_LIMIT. Else d_req wins, then f_req.
  - At most one grant per cycle.
- Memory port:
  - mem_addr, mem_wdata, mem_we, mem_re follow the granted requester in the same cycle.
  - No grant: mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Fetch grant: mem_re = 1, mem_we = 0, mem_wdata = 0.
  - Data grant with d_we != 0: mem_we = d_we, mem_re = 0, and no response is generated.
  - Data grant with d_we == 0: mem_re = 1.
- Tag pipeline:
  - LATENCY stages, each holding {valid, tag}; tag FETCH = 0, DATA = 1.
  - Stage 0 is loaded at the clock edge of each read grant. Entries shift one stage per cycle.
  - When the last stage holds a valid entry, the matching rvalid asserts in cycle N+LATENCY.
- Response outputs:
  - f_rdata and d_rdata are both driven from mem_rdata combinationally.
  - The two rvalid outputs are mutually exclusive.
  - Both rvalid outputs are registered-pipeline derived: no combinational path from the request inputs.
- Flush:
  - f_flush clears valid on every FETCH-tagged entry already in the pipeline, and forces f_rvalid = 0 in the flush cycle.
  - A fetch granted in the flush cycle itself is the redirected fetch. It is NOT squashed.
  - DATA-tagged entries are unaffected by f_flush.
- Halt: blocks new grants and holds starve_cnt. The pipeline keeps shifting, so outstanding reads return normally.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, each cycle with f_req && !f_gnt && !halt.
  - Clears to 0 on f_gnt or !f_req.
- Reset values: all pipeline valid bits 0, starve_cnt 0, f_rvalid = d_rvalid = 0, all grants 0.
- Reset mid-operation: in-flight reads are dropped. No rvalid asserts in any cycle after rst is sampled high.
- Requesters hold req and payload stable until granted. The arbiter does no request buffering.

Decomposition:
- Shared package:
  - requester tag constants TAG_FETCH = 1'b0, TAG_DATA = 1'b1;
  - memory width constants ADDR_W = 32, DATA_W = 32, BE_W = 4.
- One sub-module: resp_tag_pipe. It holds the LATENCY-deep {valid, tag} shift register with a per-tag squash input and rst clear. Its output is the last-stage valid and tag.

Test Plan:
- Fetch only, f_addr = 0x100, LATENCY = 1 -> f_gnt = 1 and mem_re = 1, mem_addr = 0x100 in cycle 0; f_rvalid = 1 in cycle 1 with f_rdata = mem_rdata; d_rvalid stays 0.
- f_req and d_req held high continuously, STARVE_LIMIT = 4 -> d_gnt in cycles 0-3, f_gnt in cycle 4, d_gnt in cycles 5-8, f_gnt in cycle 9.
- Data write d_addr = 0x203, d_we = 4'b1000, d_wdata = 0xAB000000 -> mem_we = 4'b1000, mem_re = 0, mem_wdata = 0xAB000000; no d_rvalid in any later cycle.
- LATENCY = 3; fetch read in cycle 0, data read in cycle 1, f_flush in cycle 2 -> f_rvalid never asserts, d_rvalid = 1 in cycle 4.
- Read granted in cycle 0 (LATENCY = 2), halt high in cycles 1-3 with both requests pending -> no grants and mem_re = mem_we = 0 in cycles 1-3; the cycle-0 read still returns rvalid in cycle 2; starve_cnt unchanged.
- Fetch read granted in cycle 0 (LATENCY = 2), rst high in cycle 1 -> f_rvalid stays 0 in cycle 2 and after; starve_cnt = 0; first grant after rst falls behaves as from reset.
